// File: rtl/dm_csr_bank.sv
// Debug-module register front end: decodes DMI requests, holds data/progbuf/autoexec/
// abstractcs state and issues abstract commands to the hart-side sequencer.
module dm_csr_bank #(
  parameter int unsigned NrData    = 2,
  parameter int unsigned NrProgBuf = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    dmi_req_valid_i,
  output logic                    dmi_req_ready_o,
  input  logic [40:0]             dmi_req_i,
  output logic                    dmi_resp_valid_o,
  input  logic                    dmi_resp_ready_i,
  output logic [33:0]             dmi_resp_o,
  output logic                    dmactive_o,
  output logic                    cmd_valid_o,
  output logic [31:0]             cmd_o,
  input  logic                    cmdbusy_i,
  input  logic                    cmderror_valid_i,
  input  logic [2:0]              cmderror_i,
  input  logic                    data_valid_i,
  input  logic [NrData*32-1:0]    data_i,
  output logic [NrData*32-1:0]    data_o,
  output logic [NrProgBuf*32-1:0] progbuf_o
);

  localparam int unsigned AddrData0        = 32'h04;
  localparam int unsigned AddrDmcontrol    = 32'h10;
  localparam int unsigned AddrAbstractcs   = 32'h16;
  localparam int unsigned AddrCommand      = 32'h17;
  localparam int unsigned AddrAbstractauto = 32'h18;
  localparam int unsigned AddrProgbuf0     = 32'h20;
  localparam logic [1:0]  OpRead           = 2'd1;
  localparam logic [1:0]  OpWrite          = 2'd2;
  localparam logic [2:0]  CmdErrNone       = 3'd0;
  localparam logic [2:0]  CmdErrBusy       = 3'd1;

  typedef enum logic {IDLE, RESP} state_e;

  state_e state_q, state_d;

  logic                            dmactive_q;
  logic [NrData-1:0][31:0]         data_q;
  logic [NrProgBuf-1:0][31:0]      progbuf_q;
  logic [NrData-1:0]               auto_data_q;
  logic [NrProgBuf-1:0]            auto_prog_q;
  logic [2:0]                      cmderr_q;

  logic [6:0]  req_addr;
  logic [1:0]  req_op;
  logic [31:0] req_data;
  logic        accept, is_read, is_write, is_access, cmderr_clr;
  logic [NrData-1:0]    data_sel;
  logic [NrProgBuf-1:0] prog_sel;
  logic        auto_hit;
  logic [31:0] auto_rd, rdata;

  assign req_addr   = dmi_req_i[40:34];
  assign req_op     = dmi_req_i[33:32];
  assign req_data   = dmi_req_i[31:0];
  assign accept     = dmi_req_valid_i & dmi_req_ready_o;
  assign is_read    = accept & (req_op == OpRead);
  assign is_write   = accept & (req_op == OpWrite);
  assign is_access  = (is_read | is_write) & ((data_sel != '0) | (prog_sel != '0));
  assign cmderr_clr = is_write & (req_addr == 7'(AddrAbstractcs));

  assign dmactive_o = dmactive_q;
  assign data_o     = data_q;
  assign progbuf_o  = progbuf_q;

  // Address decode and read-data mux
  always_comb begin
    data_sel = '0;
    prog_sel = '0;
    auto_hit = 1'b0;
    auto_rd  = '0;
    rdata    = '0;
    auto_rd[NrData-1:0]       = auto_data_q;
    auto_rd[16 +: NrProgBuf]  = auto_prog_q;
    for (int unsigned i = 0; i < NrData; i++) begin
      if (req_addr == 7'(AddrData0 + i)) begin
        data_sel[i] = 1'b1;
        auto_hit    = auto_data_q[i];
        rdata       = data_q[i];
      end
    end
    for (int unsigned i = 0; i < NrProgBuf; i++) begin
      if (req_addr == 7'(AddrProgbuf0 + i)) begin
        prog_sel[i] = 1'b1;
        auto_hit    = auto_prog_q[i];
        rdata       = progbuf_q[i];
      end
    end
    if (req_addr == 7'(AddrDmcontrol)) begin
      rdata = {31'b0, dmactive_q};
    end else if (req_addr == 7'(AddrAbstractcs)) begin
      rdata = {3'b0, 5'(NrProgBuf), 11'b0, cmdbusy_i, 1'b0, cmderr_q, 4'b0, 4'(NrData)};
    end else if (req_addr == 7'(AddrAbstractauto)) begin
      rdata = auto_rd;
    end
  end

  // Handshake FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = RESP;
      RESP: if (dmi_resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= IDLE;
      dmi_req_ready_o  <= 1'b0;
      dmi_resp_valid_o <= 1'b0;
      dmi_resp_o       <= '0;
    end else begin
      state_q          <= state_d;
      dmi_req_ready_o  <= (state_d == IDLE);
      dmi_resp_valid_o <= (state_d == RESP);
      if (accept) dmi_resp_o <= {(req_op == OpRead) ? rdata : 32'h0, 2'b00};
    end
  end

  // Register state; later assignments carry priority (hart error/write-back last)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dmactive_q  <= 1'b0;
      data_q      <= '0;
      progbuf_q   <= '0;
      auto_data_q <= '0;
      auto_prog_q <= '0;
      cmderr_q    <= CmdErrNone;
      cmd_o       <= '0;
      cmd_valid_o <= 1'b0;
    end else begin
      cmd_valid_o <= 1'b0;
      if (is_write && req_addr == 7'(AddrDmcontrol)) dmactive_q <= req_data[0];
      if (!dmactive_q) begin
        data_q      <= '0;
        progbuf_q   <= '0;
        auto_data_q <= '0;
        auto_prog_q <= '0;
        cmderr_q    <= CmdErrNone;
        cmd_o       <= '0;
      end else begin
        if (cmderr_clr) cmderr_q <= cmderr_q & ~req_data[10:8];
        if (is_write && req_addr == 7'(AddrCommand)) begin
          if (cmdbusy_i) begin
            if (cmderr_q == CmdErrNone) cmderr_q <= CmdErrBusy;
          end else if (cmderr_q == CmdErrNone) begin
            cmd_o       <= req_data;
            cmd_valid_o <= 1'b1;
          end
        end
        if (is_write && req_addr == 7'(AddrAbstractauto)) begin
          auto_data_q <= req_data[NrData-1:0];
          auto_prog_q <= req_data[16 +: NrProgBuf];
        end
        if (is_access) begin
          if (cmdbusy_i) begin
            if (cmderr_q == CmdErrNone) cmderr_q <= CmdErrBusy;
          end else begin
            if (is_write) begin
              for (int unsigned i = 0; i < NrData; i++)
                if (data_sel[i]) data_q[i] <= req_data;
              for (int unsigned i = 0; i < NrProgBuf; i++)
                if (prog_sel[i]) progbuf_q[i] <= req_data;
            end
            if (auto_hit && cmderr_q == CmdErrNone) cmd_valid_o <= 1'b1;
          end
        end
        if (cmderror_valid_i && (cmderr_q == CmdErrNone || cmderr_clr)) cmderr_q <= cmderror_i;
        if (data_valid_i) data_q <= data_i;
      end
    end
  end

endmodule

// File: tb/tb_dm_csr_bank.sv
// Directed testbench for dm_csr_bank (NrData=2, NrProgBuf=8).
module tb_dm_csr_bank;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         dmi_req_valid_i = 1'b0;
  logic         dmi_req_ready_o;
  logic [40:0]  dmi_req_i = '0;
  logic         dmi_resp_valid_o;
  logic         dmi_resp_ready_i = 1'b0;
  logic [33:0]  dmi_resp_o;
  logic         dmactive_o;
  logic         cmd_valid_o;
  logic [31:0]  cmd_o;
  logic         cmdbusy_i = 1'b0;
  logic         cmderror_valid_i = 1'b0;
  logic [2:0]   cmderror_i = '0;
  logic         data_valid_i = 1'b0;
  logic [63:0]  data_i = '0;
  logic [63:0]  data_o;
  logic [255:0] progbuf_o;

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;

  dm_csr_bank #(.NrData(2), .NrProgBuf(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .dmi_req_valid_i(dmi_req_valid_i), .dmi_req_ready_o(dmi_req_ready_o),
    .dmi_req_i(dmi_req_i), .dmi_resp_valid_o(dmi_resp_valid_o),
    .dmi_resp_ready_i(dmi_resp_ready_i), .dmi_resp_o(dmi_resp_o),
    .dmactive_o(dmactive_o), .cmd_valid_o(cmd_valid_o), .cmd_o(cmd_o),
    .cmdbusy_i(cmdbusy_i), .cmderror_valid_i(cmderror_valid_i), .cmderror_i(cmderror_i),
    .data_valid_i(data_valid_i), .data_i(data_i), .data_o(data_o), .progbuf_o(progbuf_o)
  );

  always #5 clk_i = ~clk_i;

  // Count command strobes, sampled mid-cycle
  always @(negedge clk_i) if (cmd_valid_o === 1'b1) pulses++;

  // One DMI transaction; side 1 injects cmderror_valid_i, side 2 data_valid_i at acceptance
  task automatic dmi(input logic [6:0] a, input logic [1:0] op, input logic [31:0] d,
                     input int side, output logic [31:0] rd);
    int n;
    dmi_req_i = {a, op, d};
    dmi_req_valid_i = 1'b1;
    n = 0;
    while (dmi_req_ready_o !== 1'b1 && n < 20) begin @(posedge clk_i); #1; n++; end
    if (n == 20) begin
      vectors++; miscompares++;
      $display("FAIL req_ready_timeout addr=%h got ready=%b want 1", a, dmi_req_ready_o);
    end
    if (side == 1) cmderror_valid_i = 1'b1;
    if (side == 2) data_valid_i = 1'b1;
    @(posedge clk_i); #1;
    dmi_req_valid_i = 1'b0;
    cmderror_valid_i = 1'b0;
    data_valid_i = 1'b0;
    n = 0;
    while (dmi_resp_valid_o !== 1'b1 && n < 20) begin @(posedge clk_i); #1; n++; end
    if (n == 20) begin
      vectors++; miscompares++;
      $display("FAIL resp_valid_timeout addr=%h got valid=%b want 1", a, dmi_resp_valid_o);
    end
    rd = dmi_resp_o[33:2];
    dmi_resp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    dmi_resp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    int p0;
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    vectors++;
    if ({dmi_req_ready_o, dmi_resp_valid_o, cmd_valid_o, dmactive_o} !== 4'b0 || data_o !== '0 || cmd_o !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got rdy=%b rv=%b cv=%b act=%b data=%h cmd=%h want all 0",
               dmi_req_ready_o, dmi_resp_valid_o, cmd_valid_o, dmactive_o, data_o, cmd_o);
    end
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    p0 = pulses;
    dmi(7'h16, 2'd1, 32'h0, 0, rd);
    vectors++;
    if (rd !== 32'h0800_0002) begin
      miscompares++; $display("FAIL reset_abstractcs got %h want 08000002", rd);
    end
    vectors++;
    if (dmi_resp_o[1:0] !== 2'b00 || pulses != p0) begin
      miscompares++; $display("FAIL reset_resp_field got resp=%b pulses=%0d want 00/0", dmi_resp_o[1:0], pulses - p0);
    end
  endtask

  task automatic test_data_rw();
    logic [31:0] rd;
    dmi(7'h10, 2'd2, 32'h1, 0, rd);
    vectors++;
    if (dmactive_o !== 1'b1) begin miscompares++; $display("FAIL dmactive_set got %b want 1", dmactive_o); end
    dmi(7'h04, 2'd2, 32'hDEAD_BEEF, 0, rd);
    dmi(7'h04, 2'd1, 32'h0, 0, rd);
    vectors++;
    if (rd !== 32'hDEAD_BEEF || data_o[31:0] !== 32'hDEAD_BEEF) begin
      miscompares++; $display("FAIL data0_rw got rd=%h out=%h want deadbeef", rd, data_o[31:0]);
    end
    dmi(7'h06, 2'd2, 32'h1234_5678, 0, rd);
    dmi(7'h06, 2'd1, 32'h0, 0, rd);
    vectors++;
    if (rd !== 32'h0 || data_o !== 64'h0000_0000_DEAD_BEEF) begin
      miscompares++; $display("FAIL unimpl_addr got rd=%h data=%h want 0/00000000deadbeef", rd, data_o);
    end
    dmi(7'h04, 2'd0, 32'h0, 0, rd);
    vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("FAIL nop_data got %h want 0", rd); end
  endtask

  task automatic test_stall();
    dmi_req_i = {7'h04, 2'd1, 32'h0};
    dmi_req_valid_i = 1'b1;
    @(posedge clk_i); #1;
    dmi_req_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (dmi_resp_valid_o !== 1'b1 || dmi_req_ready_o !== 1'b0 || dmi_resp_o !== {32'hDEAD_BEEF, 2'b00}) begin
        miscompares++;
        $display("FAIL stall_cycle%0d got rv=%b rdy=%b resp=%h want 1/0/%h", i, dmi_resp_valid_o,
                 dmi_req_ready_o, dmi_resp_o, {32'hDEAD_BEEF, 2'b00});
      end
      @(posedge clk_i); #1;
    end
    dmi_resp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    dmi_resp_ready_i = 1'b0;
    vectors++;
    if (dmi_resp_valid_o !== 1'b0 || dmi_req_ready_o !== 1'b1) begin
      miscompares++; $display("FAIL stall_release got rv=%b rdy=%b want 0/1", dmi_resp_valid_o, dmi_req_ready_o);
    end
  endtask

  task automatic test_command();
    logic [31:0] rd;
    int p0;
    p0 = pulses;
    dmi(7'h17, 2'd2, 32'h0022_1001, 0, rd);
    vectors++;
    if (pulses - p0 != 1 || cmd_o !== 32'h0022_1001) begin
      miscompares++; $display("FAIL cmd_issue got pulses=%0d cmd=%h want 1/00221001", pulses - p0, cmd_o);
    end
    cmdbusy_i = 1'b1;
    p0 = pulses;
    dmi(7'h17, 2'd2, 32'h0022_1001, 0, rd);
    dmi(7'h16, 2'd1, 32'h0, 0, rd);
    vectors++;
    if (pulses != p0 || rd !== 32'h0800_1102) begin
      miscompares++; $display("FAIL cmd_busy got pulses=%0d cs=%h want 0/08001102", pulses - p0, rd);
    end
    cmdbusy_i = 1'b0;
    dmi(7'h17, 2'd2, 32'hAAAA_5555, 0, rd);
    vectors++;
    if (pulses != p0 || cmd_o !== 32'h0022_1001) begin
      miscompares++; $display("FAIL cmd_err_block got pulses=%0d cmd=%h want 0/00221001", pulses - p0, cmd_o);
    end
    dmi(7'h16, 2'd2, 32'h0000_0700, 0, rd);
    dmi(7'h16, 2'd1, 32'h0, 0, rd);
    vectors++;
    if (rd !== 32'h0800_0002) begin miscompares++; $display("FAIL cmderr_w1c got %h want 08000002", rd); end
  endtask

  task automatic test_autoexec();
    logic [31:0] rd;
    int p0;
    dmi(7'h18, 2'd2, 32'hFFFF_FFFF, 0, rd);
    dmi(7'h18, 2'd1, 32'h0, 0, rd);
    vectors++;
    if (rd !== 32'h00FF_0003) begin miscompares++; $display("FAIL auto_mask got %h want 00ff0003", rd); end
    dmi(7'h18, 2'd2, 32'h0001_0001, 0, rd);
    p0 = pulses;
    dmi(7'h20, 2'd2, 32'h0000_0013, 0, rd);
    vectors++;
    if (pulses - p0 != 1 || progbuf_o[31:0] !== 32'h13 || cmd_o !== 32'h0022_1001) begin
      miscompares++; $display("FAIL auto_progbuf got pulses=%0d pb0=%h cmd=%h want 1/13/00221001",
                              pulses - p0, progbuf_o[31:0], cmd_o);
    end
    p0 = pulses;
    dmi(7'h04, 2'd1, 32'h0, 0, rd);
    vectors++;
    if (pulses - p0 != 1 || rd !== 32'hDEAD_BEEF) begin
      miscompares++; $display("FAIL auto_data_read got pulses=%0d rd=%h want 1/deadbeef", pulses - p0, rd);
    end
    p0 = pulses;
    dmi(7'h05, 2'd1, 32'h0, 0, rd);
    vectors++;
    if (pulses != p0) begin miscompares++; $display("FAIL auto_data1_none got pulses=%0d want 0", pulses - p0); end
    cmdbusy_i = 1'b1;
    dmi(7'h04, 2'd2, 32'h0000_1111, 0, rd);
    cmdbusy_i = 1'b0;
    dmi(7'h16, 2'd1, 32'h0, 0, rd);
    vectors++;
    if (pulses != p0 || data_o[31:0] !== 32'hDEAD_BEEF || rd !== 32'h0800_0102) begin
      miscompares++; $display("FAIL busy_data_write got pulses=%0d d0=%h cs=%h want 0/deadbeef/08000102",
                              pulses - p0, data_o[31:0], rd);
    end
    dmi(7'h16, 2'd2, 32'h0000_0700, 0, rd);
    dmi(7'h18, 2'd2, 32'h0, 0, rd);
  endtask

  task automatic test_error();
    logic [31:0] rd;
    cmdbusy_i = 1'b1;
    dmi(7'h17, 2'd2, 32'h0, 0, rd);
    cmdbusy_i = 1'b0;
    cmderror_i = 3'd3;
    dmi(7'h16, 2'd2, 32'h0000_0700, 1, rd);
    dmi(7'h16, 2'd1, 32'h0, 0, rd);
    vectors++;
    if (rd !== 32'h0800_0302) begin miscompares++; $display("FAIL err_beats_w1c got %h want 08000302", rd); end
    cmderror_i = 3'd2;
    dmi(7'h05, 2'd0, 32'h0, 1, rd);
    dmi(7'h16, 2'd1, 32'h0, 0, rd);
    vectors++;
    if (rd !== 32'h0800_0302) begin miscompares++; $display("FAIL err_sticky got %h want 08000302", rd); end
    dmi(7'h16, 2'd2, 32'h0000_0700, 0, rd);
    dmi(7'h16, 2'd1, 32'h0, 0, rd);
    vectors++;
    if (rd !== 32'h0800_0002) begin miscompares++; $display("FAIL err_clear got %h want 08000002", rd); end
  endtask

  task automatic test_data_valid();
    logic [31:0] rd;
    data_i = {32'h2222_2222, 32'h1111_1111};
    dmi(7'h04, 2'd2, 32'h5555_5555, 2, rd);
    vectors++;
    if (data_o !== 64'h2222_2222_1111_1111) begin
      miscompares++; $display("FAIL writeback_wins got %h want 2222222211111111", data_o);
    end
    dmi(7'h05, 2'd1, 32'h0, 0, rd);
    vectors++;
    if (rd !== 32'h2222_2222) begin miscompares++; $display("FAIL data1_read got %h want 22222222", rd); end
  endtask

  task automatic test_dmactive();
    logic [31:0] rd;
    int p0;
    dmi(7'h18, 2'd2, 32'h0001_0000, 0, rd);
    dmi(7'h10, 2'd2, 32'h0, 0, rd);
    p0 = pulses;
    vectors++;
    if (dmactive_o !== 1'b0) begin miscompares++; $display("FAIL dmactive_clear got %b want 0", dmactive_o); end
    dmi(7'h04, 2'd1, 32'h0, 0, rd);
    vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("FAIL inactive_data0 got %h want 0", rd); end
    dmi(7'h20, 2'd1, 32'h0, 0, rd);
    vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("FAIL inactive_progbuf0 got %h want 0", rd); end
    dmi(7'h18, 2'd1, 32'h0, 0, rd);
    vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("FAIL inactive_auto got %h want 0", rd); end
    dmi(7'h04, 2'd2, 32'h0000_0077, 0, rd);
    vectors++;
    if (data_o !== '0 || pulses != p0) begin
      miscompares++; $display("FAIL inactive_write got data=%h pulses=%0d want 0/0", data_o, pulses - p0);
    end
    dmi(7'h10, 2'd2, 32'h1, 0, rd);
    dmi(7'h04, 2'd2, 32'h0000_0077, 0, rd);
    dmi(7'h04, 2'd1, 32'h0, 0, rd);
    vectors++;
    if (rd !== 32'h77 || dmactive_o !== 1'b1) begin
      miscompares++; $display("FAIL reactivate got rd=%h act=%b want 77/1", rd, dmactive_o);
    end
  endtask

  task automatic test_reset_mid();
    dmi_req_i = {7'h04, 2'd1, 32'h0};
    dmi_req_valid_i = 1'b1;
    @(posedge clk_i); #1;
    dmi_req_valid_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    vectors++;
    if (dmi_resp_valid_o !== 1'b0 || dmactive_o !== 1'b0 || data_o !== '0) begin
      miscompares++; $display("FAIL reset_mid got rv=%b act=%b data=%h want 0/0/0", dmi_resp_valid_o, dmactive_o, data_o);
    end
    @(posedge clk_i); #1;
    vectors++;
    if (dmi_req_ready_o !== 1'b1 || dmi_resp_valid_o !== 1'b0) begin
      miscompares++; $display("FAIL reset_mid_idle got rdy=%b rv=%b want 1/0", dmi_req_ready_o, dmi_resp_valid_o);
    end
  endtask

  initial begin
    test_reset();
    test_data_rw();
    test_stall();
    test_command();
    test_autoexec();
    test_error();
    test_data_valid();
    test_dmactive();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
